// File: rtl/ps2_morse_pkg.sv
// Shared definitions for the PS/2-to-Morse encoder.
//   - scan-code constants (set 2) for the control keys
//   - 6-bit symbol encoding: 0..25 = A..Z, 26..35 = 0..9, 36 = Space
//   - scan_to_sym(): scan code -> {valid, symbol}
//   - morse_rom():   symbol -> {length, pattern}; pattern bit (length-1)
//                    is the first element, 0 = dot, 1 = dash; Space has length 0
//   - state_t: transmitter FSM states
package ps2_morse_pkg;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_F4    = 8'h0C;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [5:0] SYM_SPACE  = 6'd36;
  localparam int         FIFO_DEPTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_ELEMENT, ST_ELEM_GAP, ST_CHAR_GAP, ST_WORD_GAP
  } state_t;

  // Returns {valid, symbol}; unsupported codes (including SC_EXT) are invalid.
  function automatic logic [6:0] scan_to_sym(input logic [7:0] sc);
    logic [6:0] r;
    r = '0;
    case (sc)
      8'h1C: r = {1'b1, 6'd0};  8'h32: r = {1'b1, 6'd1};  8'h21: r = {1'b1, 6'd2};
      8'h23: r = {1'b1, 6'd3};  8'h24: r = {1'b1, 6'd4};  8'h2B: r = {1'b1, 6'd5};
      8'h34: r = {1'b1, 6'd6};  8'h33: r = {1'b1, 6'd7};  8'h43: r = {1'b1, 6'd8};
      8'h3B: r = {1'b1, 6'd9};  8'h42: r = {1'b1, 6'd10}; 8'h4B: r = {1'b1, 6'd11};
      8'h3A: r = {1'b1, 6'd12}; 8'h31: r = {1'b1, 6'd13}; 8'h44: r = {1'b1, 6'd14};
      8'h4D: r = {1'b1, 6'd15}; 8'h15: r = {1'b1, 6'd16}; 8'h2D: r = {1'b1, 6'd17};
      8'h1B: r = {1'b1, 6'd18}; 8'h2C: r = {1'b1, 6'd19}; 8'h3C: r = {1'b1, 6'd20};
      8'h2A: r = {1'b1, 6'd21}; 8'h1D: r = {1'b1, 6'd22}; 8'h22: r = {1'b1, 6'd23};
      8'h35: r = {1'b1, 6'd24}; 8'h1A: r = {1'b1, 6'd25};
      8'h45: r = {1'b1, 6'd26}; 8'h16: r = {1'b1, 6'd27}; 8'h1E: r = {1'b1, 6'd28};
      8'h26: r = {1'b1, 6'd29}; 8'h25: r = {1'b1, 6'd30}; 8'h2E: r = {1'b1, 6'd31};
      8'h36: r = {1'b1, 6'd32}; 8'h3D: r = {1'b1, 6'd33}; 8'h3E: r = {1'b1, 6'd34};
      8'h46: r = {1'b1, 6'd35};
      SC_SPACE: r = {1'b1, SYM_SPACE};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Returns {length[2:0], pattern[4:0]}.
  function automatic logic [7:0] morse_rom(input logic [5:0] sym);
    logic [7:0] r;
    r = '0;
    case (sym)
      6'd0:  r = {3'd2, 5'b00001}; 6'd1:  r = {3'd4, 5'b01000}; 6'd2:  r = {3'd4, 5'b01010};
      6'd3:  r = {3'd3, 5'b00100}; 6'd4:  r = {3'd1, 5'b00000}; 6'd5:  r = {3'd4, 5'b00010};
      6'd6:  r = {3'd3, 5'b00110}; 6'd7:  r = {3'd4, 5'b00000}; 6'd8:  r = {3'd2, 5'b00000};
      6'd9:  r = {3'd4, 5'b00111}; 6'd10: r = {3'd3, 5'b00101}; 6'd11: r = {3'd4, 5'b00100};
      6'd12: r = {3'd2, 5'b00011}; 6'd13: r = {3'd2, 5'b00010}; 6'd14: r = {3'd3, 5'b00111};
      6'd15: r = {3'd4, 5'b00110}; 6'd16: r = {3'd4, 5'b01101}; 6'd17: r = {3'd3, 5'b00010};
      6'd18: r = {3'd3, 5'b00000}; 6'd19: r = {3'd1, 5'b00001}; 6'd20: r = {3'd3, 5'b00001};
      6'd21: r = {3'd4, 5'b00001}; 6'd22: r = {3'd3, 5'b00011}; 6'd23: r = {3'd4, 5'b01001};
      6'd24: r = {3'd4, 5'b01011}; 6'd25: r = {3'd4, 5'b01100};
      6'd26: r = {3'd5, 5'b11111}; 6'd27: r = {3'd5, 5'b01111}; 6'd28: r = {3'd5, 5'b00111};
      6'd29: r = {3'd5, 5'b00011}; 6'd30: r = {3'd5, 5'b00001}; 6'd31: r = {3'd5, 5'b00000};
      6'd32: r = {3'd5, 5'b10000}; 6'd33: r = {3'd5, 5'b11000}; 6'd34: r = {3'd5, 5'b11100};
      6'd35: r = {3'd5, 5'b11110};
      default: r = '0;  // Space and unused codes: no elements
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_morse_encoder_if.sv
// Bundle of the encoder's external signals.
//   ps2_clk / ps2_data       : keyboard lines (device-to-host only)
//   ps2_received_data        : last valid scan code
//   ps2_received_data_strb   : one-cycle valid pulse for ps2_received_data
//   dit_out / dah_out        : high for the whole element
//   morse_code_out / tone_out: keying and audio square wave
// Handshake: ps2_received_data_strb is a valid-only pulse with no ready;
// the consumer must take ps2_received_data in the cycle the strobe is high
// (the data also stays stable until the next strobe).
interface ps2_morse_encoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic       dit_out;
  logic       dah_out;
  logic       morse_code_out;
  logic       tone_out;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_received_data, ps2_received_data_strb,
    input  dit_out, dah_out, morse_code_out, tone_out
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_received_data, ps2_received_data_strb,
    output dit_out, dah_out, morse_code_out, tone_out
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
//   clk, rst   : system clock, synchronous active-high reset
//   ps2_clk_i  : raw keyboard clock (asynchronous)
//   ps2_data_i : raw keyboard data (asynchronous)
//   data_o     : last scan code that passed start/parity/stop checks
//   strb_o     : one-cycle pulse when data_o is updated
// Latency from the raw stop-bit falling edge to strb_o is 3 clk
// (two synchronizer stages plus the registered output).
module ps2_frame_rx #(
  parameter int IDLE_TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] data_o,
  output logic       strb_o
);

  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_prev_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [7:0]  data_q, data_d;
  logic        strb_q, strb_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;

  logic fall, sd;
  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign sd   = data_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      data_q      <= '0;
      strb_q      <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  // bit_cnt_q: 0 = waiting for start, 1..8 = data, 9 = parity, 10 = stop.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    data_d     = data_q;
    strb_d     = 1'b0;
    idle_cnt_d = idle_cnt_q;
    if (fall) begin
      idle_cnt_d = '0;
      case (bit_cnt_q)
        4'd0: if (!sd) bit_cnt_d = 4'd1;  // a 1 here is not a start bit
        4'd9: begin
          parity_d  = sd;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (sd && (^{shift_q, parity_q})) begin
            data_d = shift_q;
            strb_d = 1'b1;
          end
        end
        default: begin
          shift_d   = {sd, shift_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_cnt_q == 32'(IDLE_TIMEOUT - 1)) begin
        bit_cnt_d  = 4'd0;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  assign data_o = data_q;
  assign strb_o = strb_q;

endmodule

// File: rtl/ps2_morse_encoder.sv
// PS/2 keyboard to Morse code encoder.
//   clk, rst    : system clock, synchronous active-high reset
//   bus (slave) : PS/2 inputs, received scan code + strobe, keying and tone
//   fsm_state_o : current transmitter state (debug)
// Keys A-Z, 0-9 and Space are queued in a 32-entry FIFO; Enter starts
// sending, F4 clears the queue and aborts after the current element.
module ps2_morse_encoder
  import ps2_morse_pkg::*;
#(
  parameter int UNIT_CYCLES  = 10000,
  parameter int TONE_HALF    = 31250,
  parameter int IDLE_TIMEOUT = 10000
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_morse_encoder_if.slave   bus,
  output state_t               fsm_state_o
);

  localparam logic [31:0] T_DIT  = 32'(UNIT_CYCLES);
  localparam logic [31:0] T_DAH  = 32'(3 * UNIT_CYCLES);
  // Gaps that lead into LOAD are one cycle short so LOAD's cycle completes them.
  localparam logic [31:0] T_CHAR = 32'(3 * UNIT_CYCLES - 1);
  // Space follows a 3-unit character gap, so it adds 4 units to reach 7.
  localparam logic [31:0] T_WORD = 32'(4 * UNIT_CYCLES - 1);

  logic [7:0] rx_data;
  logic       rx_strb;

  ps2_frame_rx #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (bus.ps2_clk),
    .ps2_data_i (bus.ps2_data),
    .data_o     (rx_data),
    .strb_o     (rx_strb)
  );

  // ---------------- key decode ----------------
  logic       brk_q, brk_d;
  logic       push, start, flush, pop;
  logic [6:0] sym_lut;
  state_t     state_q, state_d;
  logic [5:0] count_q;
  logic       fifo_empty, push_ok;

  assign sym_lut    = scan_to_sym(rx_data);
  assign fifo_empty = (count_q == 6'd0);
  assign push_ok    = push && (count_q != 6'(FIFO_DEPTH));

  always_comb begin
    brk_d = brk_q;
    push  = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    if (rx_strb) begin
      if (brk_q)                      brk_d = 1'b0;  // swallow the released key
      else if (rx_data == SC_BREAK)   brk_d = 1'b1;
      else if (rx_data == SC_ENTER)   start = (state_q == ST_IDLE) && !fifo_empty;
      else if (rx_data == SC_F4)      flush = 1'b1;
      else if (sym_lut[6])            push  = 1'b1;
    end
  end

  // ---------------- symbol FIFO ----------------
  logic [5:0] fifo_mem [FIFO_DEPTH];
  logic [4:0] wr_ptr_q, rd_ptr_q;
  logic [5:0] fifo_head;
  logic       pop_ok;

  assign fifo_head = fifo_mem[rd_ptr_q];
  assign pop_ok    = pop && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push_ok && !flush) fifo_mem[wr_ptr_q] <= sym_lut[5:0];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 5'd1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 5'd1;
      count_q <= count_q + {5'd0, push_ok} - {5'd0, pop_ok};
    end
  end

  // ---------------- transmitter FSM ----------------
  logic [31:0] tmr_q, tmr_d;
  logic [2:0]  idx_q, idx_d;
  logic [4:0]  pat_q, pat_d;
  logic        abort_q, abort_d;
  logic [7:0]  rom;
  logic [2:0]  rom_len;
  logic [4:0]  rom_pat;
  logic        tmr_done;

  assign rom      = morse_rom(fifo_head);
  assign rom_len  = rom[7:5];
  assign rom_pat  = rom[4:0];
  assign tmr_done = (tmr_q == 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      abort_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      abort_q <= abort_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q != 32'd0) ? tmr_q - 32'd1 : 32'd0;
    idx_d   = idx_q;
    pat_d   = pat_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (abort_q) begin
          state_d = ST_IDLE;
        end else begin
          pop = 1'b1;
          if (rom_len == 3'd0) begin
            state_d = ST_WORD_GAP;
            tmr_d   = T_WORD;
          end else begin
            state_d = ST_ELEMENT;
            idx_d   = rom_len - 3'd1;
            pat_d   = rom_pat;
            tmr_d   = rom_pat[rom_len - 3'd1] ? T_DAH : T_DIT;
          end
        end
      end
      ST_ELEMENT: if (tmr_done) begin
        if (idx_q == 3'd0) begin
          state_d = (abort_q || fifo_empty) ? ST_IDLE : ST_CHAR_GAP;
          tmr_d   = T_CHAR;
        end else if (abort_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ELEM_GAP;
          tmr_d   = T_DIT;
          idx_d   = idx_q - 3'd1;
        end
      end
      ST_ELEM_GAP: begin
        if (abort_q) state_d = ST_IDLE;
        else if (tmr_done) begin
          state_d = ST_ELEMENT;
          tmr_d   = pat_q[idx_q] ? T_DAH : T_DIT;
        end
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (abort_q)       state_d = ST_IDLE;
        else if (tmr_done) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) tmr_d = '0;
    abort_d = abort_q | (flush && (state_q != ST_IDLE));
    if (state_d == ST_IDLE) abort_d = 1'b0;
  end

  // ---------------- outputs ----------------
  logic dit, dah, morse;
  always_comb begin
    dit   = (state_q == ST_ELEMENT) && !pat_q[idx_q];
    dah   = (state_q == ST_ELEMENT) &&  pat_q[idx_q];
    morse = dit | dah;
  end

  logic [31:0] tone_cnt_q, tone_cnt_d;
  logic        tone_q, tone_d;

  always_comb begin
    tone_cnt_d = '0;
    tone_d     = 1'b0;
    if (morse) begin
      if (tone_cnt_q == 32'(TONE_HALF - 1)) begin
        tone_d = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 32'd1;
        tone_d     = tone_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
    end
  end

  assign bus.ps2_received_data      = rx_data;
  assign bus.ps2_received_data_strb = rx_strb;
  assign bus.dit_out                = dit;
  assign bus.dah_out                = dah;
  assign bus.morse_code_out         = morse;
  // Gate with keying so the tone stops in the same cycle the element ends.
  assign bus.tone_out               = tone_q & morse;
  assign fsm_state_o                = state_q;

endmodule

// File: tb/tb_ps2_morse_encoder.sv
module tb_ps2_morse_encoder;
  import ps2_morse_pkg::*;

  localparam int UNIT = 10;
  localparam int TH   = 3;
  localparam int ITO  = 100;
  localparam int HP   = 8;   // PS/2 clock half period in clk cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_morse_encoder_if bus();
  state_t fsm_state;

  ps2_morse_encoder #(.UNIT_CYCLES(UNIT), .TONE_HALF(TH), .IDLE_TIMEOUT(ITO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fsm_state_o (fsm_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // ---------------- monitors ----------------
  // Keying segments: {kind[1:0], length[13:0]}, kind 1=dit, 2=dah, 0=gap.
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [1:0]  mon_cur;
  logic [1:0]  mon_prev = 2'd0;
  int          mon_run = 0;
  bit          had_high = 1'b0;
  int          t_first_rise = 0;
  int          tone_hi = 0, tone_bad = 0, both_bad = 0, morse_bad = 0;
  int          n_strb = 0, strb_long = 0, t_strb = 0, last_lat = 0;
  int          t_stop = 0;
  bit          strb_prev = 1'b0;

  assign mon_cur = bus.dit_out ? 2'd1 : (bus.dah_out ? 2'd2 : 2'd0);

  always @(negedge clk) begin
    if (rst) begin
      got_q.delete();
      mon_prev <= 2'd0;
      mon_run  <= 0;
      had_high <= 1'b0;
    end else if (mon_cur == mon_prev) begin
      mon_run <= mon_run + 1;
    end else begin
      if (mon_prev != 2'd0) begin
        got_q.push_back({mon_prev, 14'(mon_run)});
        had_high <= 1'b1;
      end else if (had_high) begin
        got_q.push_back({2'd0, 14'(mon_run)});
      end else begin
        t_first_rise <= cyc;
      end
      mon_prev <= mon_cur;
      mon_run  <= 1;
    end
    if (bus.tone_out) tone_hi <= tone_hi + 1;
    if (bus.tone_out && !bus.morse_code_out) tone_bad <= tone_bad + 1;
    if (bus.dit_out && bus.dah_out) both_bad <= both_bad + 1;
    if (bus.morse_code_out != (bus.dit_out | bus.dah_out)) morse_bad <= morse_bad + 1;
    if (bus.ps2_received_data_strb) begin
      n_strb   <= n_strb + 1;
      t_strb   <= cyc;
      last_lat <= cyc - t_stop;
      if (strb_prev) strb_long <= strb_long + 1;
    end
    strb_prev <= bus.ps2_received_data_strb;
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input bit bad_par);
    logic par;
    par = ~(^code) ^ bad_par;
    return {1'b1, par, code, 1'b0};
  endfunction

  // Sends the first nbits of an LSB-first frame; starts and ends on a negedge.
  task automatic send_raw(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) t_stop = cyc;
      repeat (HP) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_raw(make_frame(code, 1'b0), 11);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (fsm_state != ST_IDLE && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, int'(fsm_state), int'(ST_IDLE));
    repeat (4) @(negedge clk);
  endtask

  // ---------------- expected keying (hand-timed) ----------------
  task automatic exp_char(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) exp_q.push_back({2'd0, 14'(UNIT)});
      if (s.getc(i) == "-") exp_q.push_back({2'd2, 14'(3 * UNIT)});
      else                  exp_q.push_back({2'd1, 14'(UNIT)});
    end
  endtask

  task automatic exp_gap(input int units);
    exp_q.push_back({2'd0, 14'(units * UNIT)});
  endtask

  task automatic check_keying(input string tag);
    check({tag, "_nseg"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_seg%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  int'(bus.ps2_received_data), 0);
    check({tag, "_strb"},  int'(bus.ps2_received_data_strb), 0);
    check({tag, "_dit"},   int'(bus.dit_out), 0);
    check({tag, "_dah"},   int'(bus.dah_out), 0);
    check({tag, "_morse"}, int'(bus.morse_code_out), 0);
    check({tag, "_tone"},  int'(bus.tone_out), 0);
    check({tag, "_state"}, int'(fsm_state), int'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0, t0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Frame reception and error handling
    s0 = n_strb;
    send_byte(8'h1C);
    check("rx_good_data", int'(bus.ps2_received_data), 'h1C);
    check("rx_good_strb", n_strb - s0, 1);
    check("rx_latency_le4", int'(last_lat <= 4), 1);
    send_raw(make_frame(8'h1C, 1'b1), 11);
    check("rx_badpar_strb", n_strb - s0, 1);
    send_raw(make_frame(8'h32, 1'b0) & 11'h3FF, 11);
    check("rx_badstop_strb", n_strb - s0, 1);
    send_raw(make_frame(8'h1C, 1'b0) | 11'h001, 11);
    repeat (ITO + 20) @(negedge clk);
    check("rx_badstart_strb", n_strb - s0, 1);
    check("rx_err_data_kept", int'(bus.ps2_received_data), 'h1C);
    send_raw(make_frame(8'h32, 1'b0), 5);
    repeat (ITO + 20) @(negedge clk);
    send_byte(8'h32);
    check("rx_timeout_data", int'(bus.ps2_received_data), 'h32);
    check("rx_timeout_strb", n_strb - s0, 2);

    // A, Enter
    do_reset();
    t0 = tone_hi;
    send_byte(8'h1C);
    send_byte(SC_ENTER);
    check("first_elem_le2", int'((t_first_rise - t_strb) <= 2), 1);
    wait_idle("a", 200);
    exp_char(".-");
    check_keying("a");
    check("a_tone_hi", tone_hi - t0, 19);

    // A, Space, B, Enter
    do_reset();
    send_byte(8'h1C); send_byte(SC_SPACE); send_byte(8'h32); send_byte(SC_ENTER);
    wait_idle("asb", 600);
    exp_char(".-"); exp_gap(7); exp_char("-...");
    check_keying("asb");

    // A, F0, C, A, Enter
    do_reset();
    send_byte(8'h1C); send_byte(SC_BREAK); send_byte(8'h21); send_byte(8'h1C);
    send_byte(SC_ENTER);
    wait_idle("brk", 600);
    exp_char(".-"); exp_gap(3); exp_char(".-");
    check_keying("brk");

    // A, B, C, F4, Space, then A, Enter
    do_reset();
    send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21); send_byte(SC_F4);
    send_byte(SC_SPACE);
    repeat (30) @(negedge clk);
    check("f4_no_keying", got_q.size(), 0);
    check("f4_idle", int'(fsm_state), int'(ST_IDLE));
    send_byte(8'h1C); send_byte(SC_ENTER);
    wait_idle("f4", 600);
    exp_char(".-");
    check_keying("f4");

    // F4 while sending "0": abort after the current dah, second "0" dropped
    do_reset();
    send_byte(8'h45); send_byte(8'h45); send_byte(SC_ENTER); send_byte(SC_F4);
    wait_idle("abort", 600);
    exp_char("-----");
    check_keying("abort");
    send_byte(SC_ENTER);
    repeat (20) @(negedge clk);
    check("abort_fifo_empty", int'(fsm_state), int'(ST_IDLE));

    // 33 x E then Enter: only 32 fit
    do_reset();
    for (int i = 0; i < 33; i++) send_byte(8'h24);
    send_byte(SC_ENTER);
    wait_idle("full", 3000);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) exp_gap(3);
      exp_char(".");
    end
    check_keying("full");

    // Reset mid-dah
    do_reset();
    send_byte(8'h1C); send_byte(SC_ENTER);
    begin
      int n = 0;
      while (!bus.dah_out && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rst_reached_dah", int'(bus.dah_out), 1);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    send_byte(SC_ENTER);
    repeat (40) @(negedge clk);
    check("midrst_fifo_empty", int'(fsm_state), int'(ST_IDLE));
    check("midrst_no_keying", got_q.size(), 0);

    // Invariants accumulated over the whole run
    check("strb_single_cycle", strb_long, 0);
    check("tone_when_silent", tone_bad, 0);
    check("dit_dah_exclusive", both_bad, 0);
    check("morse_is_or", morse_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_morse_encoder.md
PS2_MORSE_ENCODER -- requirements
Module: ps2_morse_encoder

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 10000, clk cycles per Morse unit (200 us at 50 MHz).
REQ-002 SHALL have parameter TONE_HALF, default 31250, clk cycles per tone half-period (800 Hz at 50 MHz).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 10000, clk cycles without a PS/2 falling edge before a partial frame is discarded.
REQ-004 SHALL have port clk, input, 1 bit: single system clock, 50 MHz nominal.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous, about 12 kHz.
REQ-007 SHALL have port ps2_data, input, 1 bit: keyboard data, asynchronous; the block only receives (device-to-host).
REQ-008 SHALL have port ps2_received_data, output, 8 bits: last valid scan code.
REQ-009 SHALL have port ps2_received_data_strb, output, 1 bit: one-cycle pulse when a new scan code is valid.
REQ-010 SHALL have ports dit_out and dah_out, outputs, 1 bit each: high for the full duration of a dit or dah element respectively.
REQ-011 SHALL have port morse_code_out, output, 1 bit: dit_out OR dah_out.
REQ-012 SHALL have port tone_out, output, 1 bit: audio square wave.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers and sample data on each detected falling edge of the synchronized ps2_clk.
REQ-014 SHALL accept an 11-bit frame: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
REQ-015 SHALL discard the frame without a strobe on any of: start bit 1, parity error, stop bit 0.
REQ-016 SHALL update ps2_received_data and pulse the strobe for exactly 1 cycle, no more than 4 clk after the raw ps2_clk falling edge of the stop bit.
REQ-017 SHALL reset the bit counter when IDLE_TIMEOUT cycles pass without a falling edge mid-frame.
REQ-018 SHALL decode scan code set 2 for A-Z, 0-9 and Space (0x29) into 6-bit symbols and append each to a 32-entry FIFO.
REQ-019 SHALL drop appends while the FIFO is full, with no other side effect.
REQ-020 SHALL discard the next byte after 0xF0 (break prefix); 0xE0 and all unsupported codes SHALL be ignored.
REQ-021 SHALL make Enter (0x5A) start transmission when idle and the FIFO is non-empty; Enter while transmitting SHALL be ignored.
REQ-022 SHALL make F4 (0x0C) clear the FIFO; if transmitting, it SHALL abort after the current element, all outputs 0.
REQ-023 SHALL implement an FSM with states IDLE, LOAD, ELEMENT, ELEM_GAP, CHAR_GAP and WORD_GAP.
REQ-024 LOAD SHALL pop a symbol and fetch its length (1-5) and pattern (dot=0, dash=1) from a ROM.
REQ-025 SHALL time elements and gaps as follows: dit 1 unit, dah 3 units, intra-character gap 1 unit, inter-character gap 3 units, Space 7 units of silence in place of the character gap.
REQ-026 SHALL assert the first element within 2 cycles of the Enter strobe.
REQ-027 SHALL continue until the FIFO is empty, including characters appended during transmission, then return to IDLE.
REQ-028 SHALL drive tone_out as a square wave toggling every TONE_HALF cycles while morse_code_out=1; otherwise tone_out=0 and the divider is cleared.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, clear the synchronizers, frame counter, FIFO, break flag, FSM (to IDLE) and tone divider.
REQ-030 SHALL hold all outputs at 0 the cycle after reset, including ps2_received_data=0x00, even mid-frame or mid-transmission.

Structure
REQ-031 SHALL place scan-code constants, the symbol encoding, the Morse ROM function and the FSM state type in package ps2_morse_pkg.
REQ-032 SHALL make the PS/2 frame receiver (REQ-013..017) a single sub-module, ps2_frame_rx; the FIFO, FSM and tone divider are inline.

Verification
REQ-033 Frame 0x1C, parity 0 -> ps2_received_data=0x1C, single strobe; the same frame with parity 1 -> no strobe.
REQ-034 A, Enter (UNIT_CYCLES=10) -> dit_out high 10 cycles, low 10 cycles, dah_out high 30 cycles, then IDLE.
REQ-035 A, Space, B, Enter -> ".-", 7-unit gap, "-...", with 1-unit gaps between elements.
REQ-036 A, F0, C, A, Enter -> "A A" transmitted (".-", 3-unit gap, ".-"); C not sent.
REQ-037 A, B, C, F4, Space -> no keying output; A, Enter afterwards -> only ".-".
REQ-038 33 letters then Enter -> exactly 32 characters sent; rst asserted mid-dah -> all outputs 0 next cycle, FIFO empty.
